// File: rtl/mul_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit_if                                                 |
// | Brief    : Request/result bundle between ID/EX and the mul/div unit.       |
// |            Carries div_zero when MULDIV_DIVZERO_FLAG_EN is defined.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic             div_zero;

  modport master (output start, op, rs_data, rt_data,
                  input  busy, done, hi, lo, div_zero);
  modport slave  (input  start, op, rs_data, rt_data,
                  output busy, done, hi, lo, div_zero);
`else
  modport master (output start, op, rs_data, rt_data,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_data, rt_data,
                  output busy, done, hi, lo);
`endif
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                    |
// | Brief    : Iterative MULT/MULTU/DIV/DIVU with HI/LO, plus MTHI/MTLO.       |
// |            Optional macro MULDIV_DIVZERO_FLAG_EN adds the div_zero pulse.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mul_div_unit_if.slave   bus
);

  localparam int         c_CW       = $clog2(WIDTH) + 1;
  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc_hi;
  logic [WIDTH-1:0]  r_acc_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_busy;
  logic              r_done;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic              r_div_zero;
`endif

  logic              w_signed;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic [WIDTH-1:0]  w_rs_abs;
  logic [WIDTH-1:0]  w_rt_abs;
  logic [WIDTH-1:0]  w_addend;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH:0]    w_shift;
  logic              w_ge;
  logic [WIDTH-1:0]  w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]  w_q_fix;
  logic [WIDTH-1:0]  w_r_fix;
  logic              w_divz;
  logic [WIDTH-1:0]  w_a_signed;

  assign w_signed = (bus.op == c_OP_MULT) || (bus.op == c_OP_DIV);
  assign w_rs_neg = w_signed & bus.rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & bus.rt_data[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -bus.rs_data : bus.rs_data;
  assign w_rt_abs = w_rt_neg ? -bus.rt_data : bus.rt_data;

  // Multiply: add multiplicand into the upper half, then shift the pair right.
  assign w_addend = r_acc_lo[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};

  // Divide: remainder < divisor, so the shifted value fits in WIDTH+1 bits and
  // a successful subtraction always fits back in WIDTH bits.
  assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[WIDTH-1:0] - r_b;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_q_fix    = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_r_fix    = r_neg_r ? -r_acc_hi : r_acc_hi;
  assign w_divz     = (r_b == '0);
  // Re-applying the dividend sign to |rs| reproduces the original rs_data.
  assign w_a_signed = r_neg_r ? -r_a : r_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                r_a      <= w_rs_abs;
                r_b      <= w_rt_abs;
                r_acc_hi <= '0;
                r_acc_lo <= bus.op[1] ? w_rs_abs : w_rt_abs;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              c_OP_MTHI: r_hi <= bus.rs_data;
              c_OP_MTLO: r_lo <= bus.rs_data;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_acc_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
          end else begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + c_CW'(1);
          if (r_cnt == c_CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            if (w_divz) begin
              r_hi <= w_a_signed;
              r_lo <= '1;
            end else begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
`ifdef MULDIV_DIVZERO_FLAG_EN
          r_div_zero <= r_is_div & w_divz;
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign bus.div_zero = r_div_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                                 |
// | Brief    : Self-checking bench: vector table, corner sequences, random ops |
// |            against an arithmetic reference model.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward
  // zero with the remainder taking the dividend sign.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (op)
      3'b000: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      3'b001: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      3'b010: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          lo = sq[31:0];
          hi = sr[31:0];
        end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Issues one op at a negedge and returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    bit busy_ok;
    bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(W + 1));
    chk({name, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({name, "_busy_drop"}, 64'(bus.busy), 64'd0);
    chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
`ifdef MULDIV_DIVZERO_FLAG_EN
    chk({name, "_div_zero"}, 64'(bus.div_zero), 64'(op[1] && (b == 0)));
`endif
  endtask

  task automatic done_gone(input string name);
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] mhi, mlo, ra, rb;
    logic [2:0]  rop;
    int n;
    bit saw_done;

    tbl[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    tbl[1]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg"};
    tbl[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"};
    tbl[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    tbl[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_wrap"};
    tbl[5]  = '{3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_zero"};
    tbl[6]  = '{3'b010, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div_zero_s"};
    tbl[7]  = '{3'b001, 32'd2,        32'd3,        32'd0,        32'd6,        "multu_2_3"};
    tbl[8]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2"};
    tbl[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"};
    tbl[10] = '{3'b000, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, "mult_min_1"};

    rst = 1'b0;
    bus.start = 1'b0; bus.op = 3'b000; bus.rs_data = '0; bus.rt_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, tbl[i].name);
      done_gone(tbl[i].name);
    end

    // MTLO/MTHI: single-cycle writes, no busy, no done.
    bus.start = 1'b1; bus.op = 3'b101; bus.rs_data = 32'h00001234;
    @(posedge clk); @(negedge clk);
    bus.op = 3'b100; bus.rs_data = 32'h00005678;
    chk("mtlo_lo", 64'(bus.lo), 64'h1234);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); @(negedge clk);
    bus.op = 3'b110; bus.rs_data = 32'hDEADBEEF;
    chk("mthi_hi", 64'(bus.hi), 64'h5678);
    chk("mthi_done", 64'(bus.done), 64'd0);
    @(posedge clk); @(negedge clk);
    bus.op = 3'b111;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("reserved_hi", 64'(bus.hi), 64'h5678);
    chk("reserved_lo", 64'(bus.lo), 64'h1234);
    chk("reserved_busy", 64'(bus.busy), 64'd0);

    // Start while busy is ignored; MTHI in the done cycle is accepted.
    bus.start = 1'b1; bus.op = 3'b001; bus.rs_data = 32'd6; bus.rt_data = 32'd7;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    bus.start = 1'b1; bus.op = 3'b011; bus.rs_data = 32'd9; bus.rt_data = 32'd3;
    @(negedge clk); n++;
    bus.start = 1'b0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    chk("ignore_latency", 64'(n), 64'(W + 1));
    chk("ignore_hi", 64'(bus.hi), 64'd0);
    chk("ignore_lo", 64'(bus.lo), 64'd42);
    bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'h0000ABCD;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("donecyc_mthi_hi", 64'(bus.hi), 64'hABCD);
    chk("donecyc_lo", 64'(bus.lo), 64'd42);
    chk("donecyc_no_done", 64'(bus.done), 64'd0);
    chk("donecyc_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1; bus.op = 3'b000; bus.rs_data = 32'hFFFFFFFD; bus.rt_data = 32'd7;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'd0);
    run_op(3'b001, 32'd2, 32'd3, 32'd0, 32'd6, "postrst_multu");
    done_gone("postrst_multu");

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        2: begin ra = $urandom; rb = 32'd0; end
        default: begin ra = 32'h80000000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom; end
      endcase
      model(rop, ra, rb, mhi, mlo);
      run_op(rop, ra, rb, mhi, mlo, $sformatf("rand%0d_op%0d", i, rop));
    end
    done_gone("rand_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
